dcache_wbuf: RTL

Store buffer between the DCache write port and the AXI master's single-beat write interface.
- Queues up to DEPTH word stores from the DCache and drains them in order, one per master write transaction.
- Holds back DCache block reads that hit a pending or in-flight store (read-after-write ordering), because the master's read and write paths are independent.

---
 rtl/dcache_wbuf.sv | 118 +++++++++++
 1 files changed

// File: rtl/dcache_wbuf.sv
// Store buffer between the DCache write port and the AXI master's single-beat write path.
// Optional store merging into the youngest entry is enabled by defining WBUF_MERGE_EN.
module dcache_wbuf #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned BLK_OFF = 5
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [3:0]  cpu_wen,
  input  logic [31:0] cpu_waddr,
  input  logic [31:0] cpu_wdata,
  output logic        wbuf_wrdy,
  input  logic        cpu_ren,
  input  logic [31:0] cpu_raddr,
  output logic        dev_ren,
  output logic        raw_stall,
  input  logic        dev_wrdy,
  output logic [3:0]  dev_wen,
  output logic [31:0] dev_waddr,
  output logic [31:0] dev_wdata,
  output logic        wbuf_empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [29:0]        r_addr [DEPTH];
  logic [3:0]         r_strb [DEPTH];
  logic [31:0]        r_data [DEPTH];
  logic [PW-1:0]      r_head;
  logic [PW-1:0]      r_tail;
  logic [PW:0]        r_count;
  logic               r_infl_v;
  logic [31:BLK_OFF]  r_infl_blk;

  logic               w_nonempty;
  logic               w_full;
  logic               w_store;
  logic               w_pop;
  logic               w_push;
  logic               w_merge;
  logic [PW-1:0]      w_young;
  logic [DEPTH-1:0]   w_valid;
  logic               w_match;
  logic               w_unused_bits;

  assign w_nonempty = (r_count != '0);
  assign w_full     = (r_count == (PW+1)'(DEPTH));
  assign w_store    = |cpu_wen;
  assign w_young    = r_tail - PW'(1);

  assign dev_wen    = w_nonempty ? r_strb[r_head] : '0;
  assign dev_waddr  = w_nonempty ? {r_addr[r_head], 2'b00} : '0;
  assign dev_wdata  = w_nonempty ? r_data[r_head] : '0;
  assign w_pop      = dev_wrdy & (|dev_wen);

`ifdef WBUF_MERGE_EN
  // The youngest entry cannot absorb a store if it is leaving as the head this cycle.
  assign w_merge = w_store & w_nonempty & (r_addr[w_young] == cpu_waddr[31:2])
                 & ~(w_pop & (w_young == r_head));
`else
  assign w_merge = 1'b0;
`endif

  assign wbuf_wrdy  = ~w_full | w_merge;
  assign w_push     = w_store & ~w_full & ~w_merge;
  assign wbuf_empty = ~w_nonempty & ~r_infl_v;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_infl_v   <= 1'b0;
      r_infl_blk <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PW'(1);
      if (w_pop)  r_head <= r_head + PW'(1);
      r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
      if (w_pop) begin
        r_infl_v   <= 1'b1;
        r_infl_blk <= r_addr[r_head][29:BLK_OFF-2];
      end else if (dev_wrdy) begin
        r_infl_v   <= 1'b0;
      end
    end
  end

  // Entry payload needs no reset: only entries inside the head/count window are observed.
  always_ff @(posedge aclk) begin
    if (w_push) begin
      r_addr[r_tail] <= cpu_waddr[31:2];
      r_strb[r_tail] <= cpu_wen;
      r_data[r_tail] <= cpu_wdata;
    end else if (w_merge) begin
      r_strb[w_young] <= r_strb[w_young] | cpu_wen;
      for (int unsigned b = 0; b < 4; b++) begin
        if (cpu_wen[b]) r_data[w_young][8*b +: 8] <= cpu_wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    w_valid = '0;
    w_match = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_valid[i] = ({1'b0, PW'(i) - r_head} < r_count);
      if (w_valid[i] && (r_addr[i][29:BLK_OFF-2] == cpu_raddr[31:BLK_OFF])) w_match = 1'b1;
    end
    if (r_infl_v && (r_infl_blk == cpu_raddr[31:BLK_OFF])) w_match = 1'b1;
    if (w_store && (cpu_waddr[31:BLK_OFF] == cpu_raddr[31:BLK_OFF])) w_match = 1'b1;
  end

  assign raw_stall = cpu_ren & w_match;
  assign dev_ren   = cpu_ren & ~raw_stall;

  assign w_unused_bits = ^{cpu_waddr[1:0], cpu_raddr[BLK_OFF-1:0]};

endmodule
